// File: rtl/axis_nmr_voter.sv
// rtl/axis_nmr_voter.sv - N-modular-redundancy majority voter over AXI-Stream channels
// Collects one beat per channel, votes on the held words, and reports disagreement in tuser.
module axis_nmr_voter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int TIMEOUT    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [NUM_CH+2:0]            m_axis_tuser,
  output logic [15:0]                  err_count
);
  localparam int MAJ = NUM_CH / 2 + 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_CH-1:0]                 last_q, held_q, held_d, cap;
  logic [TW-1:0]                     tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]             tdata_q, vote_data;
  logic                              tvalid_q, tlast_q, vote_last;
  logic [NUM_CH+2:0]                 tuser_q, vote_user;
  logic [15:0]                       err_q, err_d;
  logic                              all_held, any_held, expired, vote, win_found;
  logic [NUM_CH-1:0]                 match [NUM_CH];
  logic [NUM_CH-1:0]                 mask;

  assign s_axis_tready = ~held_q;
  assign cap           = s_axis_tvalid & ~held_q;
  assign all_held      = &held_q;
  assign any_held      = |held_q;
  assign expired       = (TIMEOUT > 0) && (tmo_q == TW'(TIMEOUT));
  assign vote          = (all_held || (expired && any_held)) && (!tvalid_q || m_axis_tready);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        match[i][j] = held_q[i] && held_q[j] && (data_q[i] == data_q[j]);
      end
    end
  end

  // Descending scans leave the lowest-index candidate as the final assignment.
  always_comb begin
    win_found = 1'b0;
    vote_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (held_q[i]) vote_data = data_q[i];
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (held_q[i] && ($countones(match[i]) >= MAJ)) begin
        win_found = 1'b1;
        vote_data = data_q[i];
      end
    end
    mask = '1;
    if (win_found) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mask[i] = !held_q[i] || (data_q[i] != vote_data);
      end
    end
    vote_last = &(last_q | ~held_q);
    vote_user = {(|(last_q & held_q)) && (|(~last_q & held_q)), !all_held, !win_found, mask};
  end

  // A late channel may capture on the vote edge; its beat starts the next collection.
  always_comb begin
    held_d = (held_q & {NUM_CH{~vote}}) | cap;
    tmo_d  = tmo_q;
    if (vote) begin
      tmo_d = '0;
    end else if ((TIMEOUT > 0) && any_held && !all_held && !expired) begin
      tmo_d = tmo_q + 1'b1;
    end
    err_d = err_q;
    if (vote && (|vote_user) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q   <= '0;
      data_q   <= '0;
      last_q   <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          data_q[i] <= s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          last_q[i] <= s_axis_tlast[i];
        end
      end
      if (vote) begin
        tvalid_q <= 1'b1;
        tdata_q  <= vote_data;
        tuser_q  <= vote_user;
        tlast_q  <= vote_last;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign err_count     = err_q;
endmodule

// File: tb/tb_axis_nmr_voter.sv
// tb/tb_axis_nmr_voter.sv - directed self-checking bench for axis_nmr_voter
// Instance a: 3 channels with timeout 4; instance b: 5 channels without timeout.
module tb_axis_nmr_voter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [23:0] a_tdata;
  logic [2:0]  a_tvalid, a_tready, a_tlast;
  logic [7:0]  a_mdata;
  logic        a_mvalid, a_mready, a_mlast;
  logic [5:0]  a_muser;
  logic [15:0] a_err;

  logic [39:0] b_tdata;
  logic [4:0]  b_tvalid, b_tready, b_tlast;
  logic [7:0]  b_mdata;
  logic        b_mvalid, b_mready, b_mlast;
  logic [7:0]  b_muser;
  logic [15:0] b_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_nmr_voter #(.DATA_WIDTH(8), .NUM_CH(3), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .s_axis_tlast(a_tlast), .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid),
    .m_axis_tready(a_mready), .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser),
    .err_count(a_err)
  );

  axis_nmr_voter #(.DATA_WIDTH(8), .NUM_CH(5), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .s_axis_tlast(b_tlast), .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
    .m_axis_tready(b_mready), .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser),
    .err_count(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_tdata = '0; a_tvalid = '0; a_tlast = '0; a_mready = 1'b0;
    b_tdata = '0; b_tvalid = '0; b_tlast = '0; b_mready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++; if (a_tready !== 3'b111) begin n_fail++; $display("FAIL reset_a_tready: got %b expected 111", a_tready); end
    n_checks++; if (b_tready !== 5'b11111) begin n_fail++; $display("FAIL reset_b_tready: got %b expected 11111", b_tready); end
    n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid: got %b expected 0", a_mvalid); end
    n_checks++; if (a_mdata !== 8'h00) begin n_fail++; $display("FAIL reset_mdata: got %h expected 00", a_mdata); end
    n_checks++; if (a_muser !== 6'b0) begin n_fail++; $display("FAIL reset_muser: got %b expected 000000", a_muser); end
    n_checks++; if (a_err !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", a_err); end
  endtask

  task automatic test_unanimous();
    a_mready = 1'b1;
    a_tdata = {8'd5, 8'd5, 8'd5}; a_tvalid = 3'b111; a_tlast = 3'b111;
    step();
    a_tvalid = 3'b000;
    n_checks++; if (a_tready !== 3'b000) begin n_fail++; $display("FAIL unan_captured: tready %b expected 000", a_tready); end
    n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL unan_early: mvalid %b expected 0", a_mvalid); end
    step();
    n_checks++; if (a_mvalid !== 1'b1) begin n_fail++; $display("FAIL unan_valid: got %b expected 1", a_mvalid); end
    n_checks++; if (a_mdata !== 8'd5) begin n_fail++; $display("FAIL unan_data: got %0d expected 5", a_mdata); end
    n_checks++; if (a_muser !== 6'b000000) begin n_fail++; $display("FAIL unan_user: got %b expected 000000", a_muser); end
    n_checks++; if (a_mlast !== 1'b1) begin n_fail++; $display("FAIL unan_last: got %b expected 1", a_mlast); end
    n_checks++; if (a_tready !== 3'b111) begin n_fail++; $display("FAIL unan_released: tready %b expected 111", a_tready); end
    step();
    n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL unan_drain: mvalid %b expected 0", a_mvalid); end
    n_checks++; if (a_err !== 16'd0) begin n_fail++; $display("FAIL unan_err: got %0d expected 0", a_err); end
  endtask

  task automatic test_majority();
    a_tdata = {8'd7, 8'd9, 8'd7}; a_tvalid = 3'b111; a_tlast = 3'b000;
    step();
    a_tvalid = 3'b000;
    step();
    n_checks++; if (a_mdata !== 8'd7) begin n_fail++; $display("FAIL maj_data: got %0d expected 7", a_mdata); end
    n_checks++; if (a_muser !== 6'b000010) begin n_fail++; $display("FAIL maj_user: got %b expected 000010", a_muser); end
    n_checks++; if (a_mlast !== 1'b0) begin n_fail++; $display("FAIL maj_last: got %b expected 0", a_mlast); end
    n_checks++; if (a_err !== 16'd1) begin n_fail++; $display("FAIL maj_err: got %0d expected 1", a_err); end
    step();
  endtask

  task automatic test_no_majority();
    b_mready = 1'b1;
    b_tdata = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; b_tvalid = 5'b11111; b_tlast = 5'b00001;
    step();
    b_tvalid = 5'b00000;
    step();
    n_checks++; if (b_mvalid !== 1'b1) begin n_fail++; $display("FAIL nomaj_valid: got %b expected 1", b_mvalid); end
    n_checks++; if (b_mdata !== 8'd1) begin n_fail++; $display("FAIL nomaj_data: got %0d expected 1", b_mdata); end
    n_checks++; if (b_muser !== 8'b10111111) begin n_fail++; $display("FAIL nomaj_user: got %b expected 10111111", b_muser); end
    n_checks++; if (b_mlast !== 1'b0) begin n_fail++; $display("FAIL nomaj_last: got %b expected 0", b_mlast); end
    n_checks++; if (b_err !== 16'd1) begin n_fail++; $display("FAIL nomaj_err: got %0d expected 1", b_err); end
    step();
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    a_tdata = {8'h00, 8'hA5, 8'hA5}; a_tvalid = 3'b011; a_tlast = 3'b011;
    step();
    a_tvalid = 3'b000;
    n_checks++; if (a_tready !== 3'b100) begin n_fail++; $display("FAIL tmo_partial: tready %b expected 100", a_tready); end
    for (int k = 0; k < 4; k++) begin
      step();
      if (a_mvalid !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL tmo_early: mvalid seen 1 expected 0 for 4 partial cycles"); end
    step();
    n_checks++; if (a_mvalid !== 1'b1) begin n_fail++; $display("FAIL tmo_valid: got %b expected 1", a_mvalid); end
    n_checks++; if (a_mdata !== 8'hA5) begin n_fail++; $display("FAIL tmo_data: got %h expected a5", a_mdata); end
    n_checks++; if (a_muser !== 6'b010100) begin n_fail++; $display("FAIL tmo_user: got %b expected 010100", a_muser); end
    n_checks++; if (a_mlast !== 1'b1) begin n_fail++; $display("FAIL tmo_last: got %b expected 1", a_mlast); end
    n_checks++; if (a_err !== 16'd2) begin n_fail++; $display("FAIL tmo_err: got %0d expected 2", a_err); end
    step();
  endtask

  task automatic test_backpressure();
    bit unstable = 1'b0;
    a_mready = 1'b0;
    a_tdata = {8'd3, 8'd3, 8'd3}; a_tvalid = 3'b111; a_tlast = 3'b111;
    step();
    a_tdata = {8'd4, 8'd4, 8'd4};
    step();
    step();
    a_tvalid = 3'b000;
    for (int k = 0; k < 10; k++) begin
      if (a_mvalid !== 1'b1 || a_mdata !== 8'd3 || a_muser !== 6'b0 || a_tready !== 3'b000) unstable = 1'b1;
      step();
    end
    n_checks++; if (unstable) begin n_fail++; $display("FAIL bp_stall: output or tready changed while stalled, mdata %0d tready %b expected 3 and 000", a_mdata, a_tready); end
    a_mready = 1'b1;
    step();
    n_checks++; if (a_mvalid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b expected 1", a_mvalid); end
    n_checks++; if (a_mdata !== 8'd4) begin n_fail++; $display("FAIL bp_second_data: got %0d expected 4", a_mdata); end
    n_checks++; if (a_tready !== 3'b111) begin n_fail++; $display("FAIL bp_released: tready %b expected 111", a_tready); end
    step();
    n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: mvalid %b expected 0", a_mvalid); end
    n_checks++; if (a_err !== 16'd2) begin n_fail++; $display("FAIL bp_err: got %0d expected 2", a_err); end
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    a_mready = 1'b0;
    a_tdata = {8'd1, 8'd1, 8'd1}; a_tvalid = 3'b111; a_tlast = 3'b111;
    step();
    a_tvalid = 3'b000;
    step();
    a_tdata = {8'd0, 8'd2, 8'd2}; a_tvalid = 3'b011;
    step();
    a_tvalid = 3'b000;
    n_checks++; if (a_tready !== 3'b100 || a_mvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: tready %b mvalid %b expected 100 and 1", a_tready, a_mvalid); end
    rst = 1'b1;
    #1;
    n_checks++; if (a_tready !== 3'b111) begin n_fail++; $display("FAIL rmid_tready: got %b expected 111", a_tready); end
    n_checks++; if (a_mvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_mvalid: got %b expected 0", a_mvalid); end
    n_checks++; if (a_err !== 16'd0) begin n_fail++; $display("FAIL rmid_err: got %0d expected 0", a_err); end
    step();
    rst = 1'b0;
    a_mready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (a_mvalid !== 1'b0) stale = 1'b1;
    end
    n_checks++; if (stale) begin n_fail++; $display("FAIL rmid_stale: mvalid seen 1 after reset expected 0"); end
  endtask

  initial begin
    test_reset();
    test_unanimous();
    test_majority();
    test_no_majority();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_nmr_voter.md
AXIS_NMR_VOTER -- requirements
Module: axis_nmr_voter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the width of each data word.
REQ-002 The block SHALL have parameter NUM_CH, default 3, setting the number of redundant input channels; legal values are odd, 3..7.
REQ-003 The block SHALL have parameter TIMEOUT, default 0, setting the partial-collection timeout in cycles; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port s_axis_tdata, input, NUM_CH*DATA_WIDTH bits: channel i data at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port s_axis_tvalid, input, NUM_CH bits: per-channel valid.
REQ-008 The block SHALL have port s_axis_tready, output, NUM_CH bits: per-channel ready.
REQ-009 The block SHALL have port s_axis_tlast, input, NUM_CH bits: per-channel last.
REQ-010 The block SHALL have port m_axis_tdata, output, DATA_WIDTH bits: voted word.
REQ-011 The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1): the output handshake.
REQ-012 The block SHALL have port m_axis_tuser, output, NUM_CH+3 bits, carrying the vote status defined below.
REQ-013 The block SHALL have port err_count, output, 16 bits: saturating count of flagged results.

Function
REQ-014 Each channel SHALL have a one-entry holding register with a held flag; s_axis_tready[i] = ~held[i].
REQ-015 A beat on channel i SHALL be captured (data, tlast, held <= 1) on a clock edge where s_axis_tvalid[i] && s_axis_tready[i].
REQ-016 A vote SHALL fire when (all held) or (timeout expired and at least one held), AND the output register is empty or m_axis_tready=1 in the same cycle.
REQ-017 On a vote edge the block SHALL load the output register, set m_axis_tvalid=1, and clear all held flags and the timeout counter.
REQ-018 Latency: a vote SHALL fire on the edge after the last capture, and m_axis_tvalid SHALL be high the cycle after that edge; peak throughput is one result per 2 cycles.
REQ-019 Majority rule: the winner SHALL be the lowest-index held channel i whose data equals that of at least NUM_CH/2+1 held channels (self included); missing channels never match.
REQ-020 If there is no winner, the block SHALL output channel 0 data if channel 0 is held, else the lowest-index held channel's data.
REQ-021 m_axis_tuser[NUM_CH-1:0] SHALL be the disagree mask: bit i = 1 if channel i is not held or its data differs from the output; all ones when there is no winner.
REQ-022 m_axis_tuser[NUM_CH] SHALL be no_majority, [NUM_CH+1] SHALL be timeout (the vote fired with fewer than NUM_CH held), and [NUM_CH+2] SHALL be last_mismatch (the tlast values of the held channels differ).
REQ-023 m_axis_tlast SHALL be the AND of tlast over the held channels.
REQ-024 Timeout counter (when TIMEOUT>0): SHALL increment each cycle while 0 < held count < NUM_CH; expiry occurs when count == TIMEOUT; the counter SHALL hold at TIMEOUT while the vote is stalled by the output.
REQ-025 The output register SHALL hold data, tuser and tlast stable while m_axis_tvalid=1 and m_axis_tready=0; m_axis_tvalid SHALL drop after a handshake unless a new vote loads on the same edge.
REQ-026 err_count SHALL increment on each vote edge where any tuser bit is 1, and SHALL saturate at 16'hFFFF.

Reset
REQ-027 Asserting rst SHALL immediately clear all held flags, the timeout counter, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast and err_count, so s_axis_tready resets to all ones.
REQ-028 Reset mid-collection or mid-output SHALL discard all partial and pending results without emitting them.

Verification
REQ-029 NUM_CH=3, beats 5/5/5 on the same cycle, m_axis_tready=1 -> data 5, tuser 0, tvalid high 2 cycles after the capture cycle, err_count 0.
REQ-030 NUM_CH=3, beats 7/9/7 -> data 7, mask 3'b010, no_majority 0, err_count 1.
REQ-031 NUM_CH=5, beats 1/2/3/4/5 -> data 1, mask 5'b11111, no_majority 1.
REQ-032 NUM_CH=3, TIMEOUT=4, channels 0 and 1 send A, channel 2 is silent -> vote after 4 partial cycles, data A, mask 3'b100, timeout 1.
REQ-033 m_axis_tready held low for 10 cycles with a result pending and new beats arriving -> output stays stable, inputs are captured then stalled (tready low), results are released in order once m_axis_tready goes high.
REQ-034 rst asserted with two channels held and a result pending -> all s_axis_tready go high, m_axis_tvalid goes low, and no stale result appears after reset.
